// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Streams a program into instruction memory while holding the mips16 core in
// reset. It then releases the core and watches its PC. A run completes when the
// PC parks on a self-branch, or when the cycle budget runs out.
module imem_boot_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int STALL_LIMIT = 4,
    parameter int MAX_CYCLES  = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              s_valid,
    input  logic [15:0]       s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              core_rst,
    input  logic [15:0]       pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [ADDR_W:0]   words_loaded,
    output logic [31:0]       cycle_count
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [ADDR_W:0]    DEPTH_LEN    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    LEN_ONE      = (ADDR_W + 1)'(1);
    localparam logic [STALL_W-1:0] STALL_ONE    = STALL_W'(1);
    localparam logic [STALL_W-1:0] STALL_END    = STALL_W'(STALL_LIMIT - 1);
    localparam logic [31:0]        CYCLE_BUDGET = 32'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [ADDR_W:0]    len_reg;
    logic [15:0]        prev_pc_reg;
    logic [STALL_W-1:0] stall_reg;
    logic               first_run_reg;

    logic               handshake;
    logic [ADDR_W:0]    start_len;
    logic [ADDR_W:0]    words_next;
    logic               pc_match;
    logic [STALL_W-1:0] stall_next;
    logic               halt;
    logic [31:0]        cycle_count_next;
    logic               budget_hit;

    // Memory writes happen in the same cycle as the handshake.
    // Write data is zeroed when no write is taking place.
    assign handshake  = s_valid & s_ready;
    assign imem_we    = handshake;
    assign imem_addr  = words_loaded[ADDR_W-1:0];
    assign imem_wdata = handshake ? s_data : 16'h0000;

    // Requests longer than the memory are clamped, so addresses never wrap.
    assign start_len  = (load_len > DEPTH_LEN) ? DEPTH_LEN : load_len;
    assign words_next = words_loaded + LEN_ONE;

    // On the first RUN cycle prev_pc still holds a stale value, so the compare
    // is suppressed. Halt fires when the updated stall count reaches
    // STALL_LIMIT-1 matching compares, which means the PC has been stable for
    // STALL_LIMIT cycles.
    assign pc_match         = !first_run_reg && (pc == prev_pc_reg);
    assign stall_next       = pc_match ? (stall_reg + STALL_ONE) : '0;
    assign halt             = pc_match && (stall_next == STALL_END);
    assign cycle_count_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count
                                                             : cycle_count + 32'd1;
    assign budget_hit       = (cycle_count_next >= CYCLE_BUDGET);

    // Controller FSM. Status outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            len_reg       <= '0;
            prev_pc_reg   <= '0;
            stall_reg     <= '0;
            first_run_reg <= 1'b1;
            core_rst      <= 1'b1;
            s_ready       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
            words_loaded  <= '0;
            cycle_count   <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        len_reg       <= start_len;
                        words_loaded  <= '0;
                        cycle_count   <= '0;
                        timeout       <= 1'b0;
                        stall_reg     <= '0;
                        first_run_reg <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        if (start_len != '0) begin
                            state_reg <= S_LOAD;
                            s_ready   <= 1'b1;
                            core_rst  <= 1'b1;
                        end else begin
                            state_reg <= S_RUN;
                            s_ready   <= 1'b0;
                            core_rst  <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        words_loaded <= words_next;
                        if (words_next == len_reg) begin
                            state_reg     <= S_RUN;
                            s_ready       <= 1'b0;
                            core_rst      <= 1'b0;
                            first_run_reg <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cycle_count   <= cycle_count_next;
                    prev_pc_reg   <= pc;
                    first_run_reg <= 1'b0;
                    stall_reg     <= stall_next;
                    if (halt) begin
                        state_reg <= S_DONE;
                        timeout   <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else if (budget_hit) begin
                        state_reg <= S_DONE;
                        timeout   <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    core_rst  <= 1'b1;
                    s_ready   <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Testbench for imem_boot_ctrl. The stimulus process issues loads and runs.
// For each one it queues the expected memory writes and the expected outcome.
// A separate monitor process pops and compares these when the DUT writes
// memory or raises done.
module tb_imem_boot_ctrl;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int SL     = 4;
    localparam int MAXC   = 20;
    localparam int SEQ_N  = MAXC + 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   load_len = '0;
    logic              s_valid = 1'b0;
    logic [15:0]       s_data = '0;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              core_rst;
    logic [15:0]       pc = '0;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [ADDR_W:0]   words_loaded;
    logic [31:0]       cycle_count;

    imem_boot_ctrl #(
        .ADDR_W     (ADDR_W),
        .STALL_LIMIT(SL),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .load_len    (load_len),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_rst    (core_rst),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .words_loaded(words_loaded),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] to;
        logic [31:0] words;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    wr_t w_exp;
    dn_t d_exp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: memory writes and run completions against the scoreboard queues.
    logic        done_prev = 1'b0;
    logic [31:0] frozen_cc = '0;
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we) begin
                check("write_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    w_exp = wq.pop_front();
                    check("wr_addr", 32'(imem_addr), w_exp.addr);
                    check("wr_data", 32'(imem_wdata), w_exp.data);
                    $display("write addr=%0d data=0x%04h", imem_addr, imem_wdata);
                end
            end
            if (done && !done_prev) begin
                check("done_expected", 32'(dq.size() > 0), 32'd1);
                if (dq.size() > 0) begin
                    d_exp = dq.pop_front();
                    check("done_cycle_count", cycle_count, d_exp.cyc);
                    check("done_timeout", 32'(timeout), d_exp.to);
                    check("done_words_loaded", 32'(words_loaded), d_exp.words);
                    $display("done cycles=%0d timeout=%0d words=%0d", cycle_count, timeout, words_loaded);
                end
                frozen_cc = cycle_count;
            end else if (done && done_prev) begin
                check("cycle_count_frozen", cycle_count, frozen_cc);
            end
        end
        done_prev = done;
    end

    // One transaction: start a load, stream the words, and drive the PC through
    // the run until done. pc_mode selects the PC pattern: 0 = random with many
    // repeats, 1 = 0,1,2,3 and then held, 2 = incrementing forever.
    task automatic do_test(input string tag, input int len, input bit bubbles,
                           input int abort_after, input int pc_mode, input bit fixed_data);
        logic [15:0] data[$];
        logic [15:0] seq[SEQ_N];
        int eff, sent, guard, i, cyc;
        bit to, same;

        eff = (len > DEPTH) ? DEPTH : len;
        for (int k = 0; k < eff; k++)
            data.push_back(fixed_data ? 16'((k + 1) * 16'h1111) : 16'($urandom));

        for (int k = 0; k < SEQ_N; k++) begin
            case (pc_mode)
                1:       seq[k] = (k < 3) ? 16'(k) : 16'd3;
                2:       seq[k] = 16'(k + 100);
                default: seq[k] = (k > 0 && $urandom_range(0, 1) == 1) ? seq[k-1]
                                                                       : 16'($urandom_range(0, 3));
            endcase
        end

        // Reference outcome: the first run cycle k that ends a window of SL
        // equal PC values halts after k+1 cycles. Otherwise the budget expires
        // at MAXC. A halt on the budget cycle still counts as a halt.
        cyc = MAXC;
        to  = 1'b1;
        for (int k = SL - 1; k < MAXC; k++) begin
            same = 1'b1;
            for (int j = 1; j < SL; j++)
                if (seq[k-j] != seq[k]) same = 1'b0;
            if (same) begin
                cyc = k + 1;
                to  = 1'b0;
                break;
            end
        end

        for (int k = 0; k < eff; k++)
            wq.push_back('{addr: 32'(k), data: 32'(data[k])});
        if (abort_after < 0)
            dq.push_back('{cyc: 32'(cyc), to: 32'(to), words: 32'(eff)});

        $display("start %s len=%0d eff=%0d bubbles=%0d pc_mode=%0d exp_cycles=%0d exp_timeout=%0d",
                 tag, len, eff, bubbles, pc_mode, cyc, to);

        start    = 1'b1;
        load_len = (ADDR_W + 1)'(len);
        s_valid  = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_core_rst_after_start"}, 32'(core_rst), (eff > 0) ? 32'd1 : 32'd0);

        sent  = 0;
        guard = 0;
        while (sent < eff && guard < 8 * eff + 20) begin
            check({tag, "_s_ready_in_load"}, 32'(s_ready), 32'd1);
            s_valid  = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data   = s_valid ? data[sent] : 16'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            load_len = (ADDR_W + 1)'($urandom);
            @(posedge clk); #1;
            if (s_valid) sent++;
            guard++;
            if (abort_after >= 0 && sent == abort_after) begin
                s_valid = 1'b0;
                start   = 1'b0;
                check({tag, "_words_before_abort"}, 32'(words_loaded), 32'(abort_after));
                #2 rst = 1'b1;
                #1;
                check({tag, "_abort_core_rst"}, 32'(core_rst), 32'd1);
                check({tag, "_abort_s_ready"}, 32'(s_ready), 32'd0);
                check({tag, "_abort_words_loaded"}, 32'(words_loaded), 32'd0);
                check({tag, "_abort_busy"}, 32'(busy), 32'd0);
                wq.delete();
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                return;
            end
        end
        check({tag, "_words_sent"}, 32'(sent), 32'(eff));

        start = 1'b0;
        check({tag, "_core_rst_in_run"}, 32'(core_rst), 32'd0);
        check({tag, "_s_ready_in_run"}, 32'(s_ready), 32'd0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'(eff));

        i = 0;
        while (i < MAXC + 5) begin
            pc       = seq[i];
            s_valid  = 1'($urandom_range(0, 1));
            s_data   = 16'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            load_len = (ADDR_W + 1)'($urandom);
            @(posedge clk); #1;
            i++;
            if (done) break;
        end
        start   = 1'b0;
        s_valid = 1'b0;
        check({tag, "_done_latency"}, 32'(i), 32'(cyc));
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_core_rst_in_done"}, 32'(core_rst), 32'd0);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        check("reset_core_rst", 32'(core_rst), 32'd1);
        check("reset_s_ready", 32'(s_ready), 32'd0);
        check("reset_imem_we", 32'(imem_we), 32'd0);
        check("reset_imem_addr", 32'(imem_addr), 32'd0);
        check("reset_imem_wdata", 32'(imem_wdata), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        check("reset_words_loaded", 32'(words_loaded), 32'd0);
        check("reset_cycle_count", cycle_count, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_test("four_words", 4, 1'b0, -1, 1, 1'b1);
        do_test("bubbles", 4, 1'b1, -1, 1, 1'b1);
        do_test("timeout", 3, 1'b0, -1, 2, 1'b0);
        do_test("zero_len", 0, 1'b0, -1, 0, 1'b0);
        do_test("clamp300", 300, 1'b0, -1, 1, 1'b0);
        do_test("abort", 5, 1'b0, 2, 0, 1'b0);
        do_test("after_abort", 6, 1'b1, -1, 1, 1'b0);
        for (int t = 0; t < 14; t++)
            do_test("random", $urandom_range(0, 20), 1'($urandom_range(0, 1)), -1,
                    $urandom_range(0, 2), 1'b0);

        check("write_queue_drained", 32'(wq.size()), 32'd0);
        check("done_queue_drained", 32'(dq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
